gpio_poll_sequencer: RTL

//  Avalon-MM master that polls a 2-bit input PIO data register (addr 0, read latency 1) on a programmable period.

---
 rtl/gpio_poll_sequencer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_poll_sequencer.sv
// Purpose : Avalon-MM master that polls a PIO data register on a programmable period,
//           debounces each input bit, latches sticky edges and raises a level IRQ.
// Latency : poll interval PERIOD+2 cycles; acceptance after DEBOUNCE polls; CSR read latency 1.
// Backpres: none; the PIO read has a fixed latency of 1, so no waitrequest is honoured.
//
// Ports:
//   clk, reset_n                     system clock, asynchronous active-low reset
//   avm_address/avm_read/avm_readdata   master side towards the PIO slave (addr always 0)
//   s_address/s_read/s_write/s_writedata/s_readdata   CSR slave side
//   irq                              |(EDGE & IRQMASK), registered level interrupt
//
// CSR map: 0 CTRL RW {FALL_EN,RISE_EN,EN} | 1 DEBOUNCED RO | 2 EDGE W1C | 3 IRQMASK RW
//          4 PERIOD RW (0 behaves as 1) | 5 TIMESTAMP RO (only with GPIO_POLL_TIMESTAMP_EN)
//
// Build option: define GPIO_POLL_TIMESTAMP_EN to add a free-running cycle counter that is
// captured into TIMESTAMP whenever an EDGE bit is set. Without it, address 5 reads 0.

module gpio_poll_sequencer #(
  parameter int WIDTH       = 2,
  parameter int POLL_PERIOD = 1000,
  parameter int DEBOUNCE    = 3,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  // PIO master side
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  // CSR slave side
  input  logic [2:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  // Stable counters only need to reach DEBOUNCE, then they saturate.
  localparam int              SW       = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0]   STAB_MAX = SW'(DEBOUNCE);

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_DEB   = 3'd1;
  localparam logic [2:0] A_EDGE  = 3'd2;
  localparam logic [2:0] A_MASK  = 3'd3;
  localparam logic [2:0] A_PER   = 3'd4;
  localparam logic [2:0] A_TS    = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   eff_period;
  logic [CNT_W-1:0]   reload;
  logic [2:0]         ctrl;
  logic [WIDTH-1:0]   debounced;
  logic [WIDTH-1:0]   edge_flags;
  logic [WIDTH-1:0]   irqmask;
  logic [WIDTH-1:0]   last;
  logic [WIDTH-1:0]   last_n;
  logic [SW-1:0]      stab   [WIDTH];
  logic [SW-1:0]      stab_n [WIDTH];
  logic [WIDTH-1:0]   sample;
  logic [WIDTH-1:0]   accept;
  logic [WIDTH-1:0]   edge_set;
  logic [WIDTH-1:0]   edge_clr;
  logic [31:0]        rdata;
  logic [31:0]        ts_rd;

  logic en;
  logic rise_en;
  logic fall_en;
  logic start;
  logic capture;
  logic wr_ctrl;
  logic wr_edge;
  logic wr_mask;
  logic wr_per;

  // Only the low WIDTH bits of the bus words carry information.
  logic unused_bits;
  assign unused_bits = ^{avm_readdata, s_writedata};

  assign en      = ctrl[0];
  assign rise_en = ctrl[1];
  assign fall_en = ctrl[2];

  assign wr_ctrl = s_write && (s_address == A_CTRL);
  assign wr_edge = s_write && (s_address == A_EDGE);
  assign wr_mask = s_write && (s_address == A_MASK);
  assign wr_per  = s_write && (s_address == A_PER);

  assign avm_address = 2'b00;

  // A zero period would otherwise underflow the reload; treat it as one cycle.
  assign eff_period = (period == '0) ? CNT_W'(1) : period;
  assign reload     = eff_period - CNT_W'(1);

  // Leaving IDLE with EN set restarts debouncing from scratch.
  assign start   = (state == IDLE) && en;
  assign capture = (state == CAPTURE);
  assign sample  = avm_readdata[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Poll FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    avm_read = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_n = WAIT;
      end
      WAIT: begin
        if (!en)             state_n = IDLE;
        else if (cnt == '0)  state_n = READ;
      end
      READ: begin
        // A read once issued is always followed by its capture.
        avm_read = 1'b1;
        state_n  = CAPTURE;
      end
      CAPTURE: begin
        state_n = en ? WAIT : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Period counter: PERIOD is only sampled at reload, so mid-wait writes
  // affect the following interval.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start || (capture && en)) begin
      cnt <= reload;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce and edge detection
  // ---------------------------------------------------------------------------
  always_comb begin
    last_n = last;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      stab_n[i] = stab[i];
      if (start) begin
        stab_n[i] = '0;
        last_n[i] = 1'b0;
      end else if (capture) begin
        if (sample[i] == last[i]) begin
          if (stab[i] != STAB_MAX) stab_n[i] = stab[i] + SW'(1);
        end else begin
          stab_n[i] = SW'(1);
          last_n[i] = sample[i];
        end
        // Once the count saturates the value has already been accepted,
        // so the inequality keeps a steady input from re-triggering.
        accept[i] = (stab_n[i] == STAB_MAX) && (sample[i] != debounced[i]);
      end
    end
  end

  assign edge_set = (accept &  sample & {WIDTH{rise_en}})
                  | (accept & ~sample & {WIDTH{fall_en}});
  assign edge_clr = wr_edge ? s_writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= '0;
      for (int i = 0; i < WIDTH; i++) stab[i] <= '0;
    end else begin
      last <= last_n;
      for (int i = 0; i < WIDTH; i++) stab[i] <= stab_n[i];
    end
  end

  // ---------------------------------------------------------------------------
  // CSR registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl       <= '0;
      debounced  <= '0;
      edge_flags <= '0;
      irqmask    <= '0;
      period     <= CNT_W'(POLL_PERIOD);
      irq        <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl    <= s_writedata[2:0];
      if (wr_mask) irqmask <= s_writedata[WIDTH-1:0];
      if (wr_per)  period  <= s_writedata[CNT_W-1:0];
      // Accepted bits always differ from the old value, so a toggle suffices.
      debounced  <= debounced ^ accept;
      // A new edge in the same cycle as its clear must not be lost.
      edge_flags <= (edge_flags & ~edge_clr) | edge_set;
      irq        <= |(edge_flags & irqmask);
    end
  end

`ifdef GPIO_POLL_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] timestamp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt    <= '0;
      timestamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (|edge_set) timestamp <= ts_cnt;
    end
  end

  assign ts_rd = timestamp;
`else
  assign ts_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (s_address)
      A_CTRL: rdata[2:0]       = ctrl;
      A_DEB:  rdata[WIDTH-1:0] = debounced;
      A_EDGE: rdata[WIDTH-1:0] = edge_flags;
      A_MASK: rdata[WIDTH-1:0] = irqmask;
      A_PER:  rdata[CNT_W-1:0] = period;
      A_TS:   rdata            = ts_rd;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= '0;
    end else begin
      s_readdata <= s_read ? rdata : 32'd0;
    end
  end

endmodule
